comp_seq: RTL and testbench
===========================

COMP_SEQ -- requirements
Module: comp_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits.
REQ-002 SHALL have parameter DIGIT, default 2, meaning bits compared per cycle; WIDTH % DIGIT == 0 and DIGIT >= 1 are required, and elaboration SHALL fail otherwise.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a request to latch operands and begin a comparison.
REQ-006 SHALL have port abort, input, 1, which cancels the comparison in progress.
REQ-007 SHALL have port signed_mode, input, 1: 1 means two's-complement comparison, 0 means unsigned.
REQ-008 SHALL have ports a and b, input, WIDTH each, the operands.
REQ-009 SHALL have port busy, output, 1, high while in RUN.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse when a result is ready.
REQ-011 SHALL have ports eq, gt and lt, output, 1 each: the result (a==b, a>b, a<b), registered and held until the next completion.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; N = WIDTH/DIGIT slices; slice index counter width $clog2(N), minimum 1.
REQ-013 SHALL, in IDLE or DONE with start=1 at a rising edge, latch a, b and signed_mode, load slice index N-1 (MSB slice), clear the internal cascade to EQ=1/GT=0, and go to RUN.
REQ-014 SHALL ignore start while in RUN, with no re-latch and no restart.
REQ-015 SHALL, in each RUN cycle, compare the current DIGIT-bit slice of the latched operands with cascade rule: GT_next = GT | (EQ & slice_a > slice_b); EQ_next = EQ & (slice_a == slice_b).
REQ-016 SHALL, when signed_mode is latched high, invert bit WIDTH-1 of both operands before the slice compare; no other slice is affected.
REQ-017 SHALL terminate early: at the end of the RUN cycle in which EQ_next=0, or at the end of the cycle processing slice 0, register eq/gt/lt and go to DONE.
REQ-018 SHALL assert done high exactly k cycles after the edge that sampled start, for one cycle, where k = 1 + number of leading equal slices (max N); busy is low in that cycle.
REQ-019 SHALL have exactly one of eq/gt/lt high after any completion; lt = !EQ_next & !GT_next.
REQ-020 SHALL, from DONE, go to IDLE on the next edge unless start=1, which begins a new comparison back-to-back.
REQ-021 SHALL, when abort=1 in RUN, go to IDLE on that edge with no done pulse and eq/gt/lt unchanged; abort has priority over completion in the same cycle; abort outside RUN has no effect.
REQ-022 SHALL NOT change eq/gt/lt before completion of a new comparison when a/b change after latching.

Reset
REQ-023 SHALL, while reset_n=0, immediately (asynchronously) force state IDLE, busy=0, done=0, eq=0, gt=0, lt=0, and the slice index and cascade registers to 0, including mid-RUN.
REQ-024 SHALL remain in IDLE on the first edge after reset_n deasserts unless start=1.

Structure
REQ-025 SHALL keep the FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) as localparams in the shared package comp_pkg.
REQ-026 SHALL contain one combinational sub-module comp_slice, parameterised by DIGIT (inputs EQ_in, GT_in, slice A, slice B; outputs EQ_out, GT_out), instantiated once and reused every cycle.

Verification (WIDTH=8, DIGIT=2, N=4)
REQ-027 SHALL cover: a=0x5A, b=0x5A, unsigned -> done 4 cycles after start, eq=1, gt=0, lt=0.
REQ-028 SHALL cover: a=0x80, b=0x7F, unsigned -> done 1 cycle after start, gt=1; repeat with signed_mode=1 -> done after 1 cycle, lt=1.
REQ-029 SHALL cover: a=0x12, b=0x13, unsigned -> done after 4 cycles, lt=1; busy high for 4 cycles before it.
REQ-030 SHALL cover: start a=0x40, b=0x41, then in RUN cycle 2 assert start with a=0xFF -> ignored, lt=1 after 4 cycles; then back-to-back start in DONE with a=0x03, b=0x01 -> gt=1 after 4 cycles.
REQ-031 SHALL cover: after a completed eq=1, start a=0x01, b=0x02 and assert abort in RUN cycle 2 -> IDLE, no done pulse, eq stays 1.
REQ-032 SHALL cover: drive reset_n low mid-RUN, asynchronously off-edge -> busy, done, eq, gt and lt go to 0 before the next edge; after release, no done pulse occurs without start.

Source files
------------

// File: rtl/comp_pkg.sv
`timescale 1ns/1ps
// comp_pkg
//   Shared declarations for the sequential magnitude comparator comp_seq:
//   FSM state encodings and a helper that sizes the slice index counter.
package comp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Counter width for n slices; a single-slice design still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/comp_slice.sv
`timescale 1ns/1ps
// comp_slice
//   One step of the MSB-first comparison cascade. Folds the relation of one
//   DIGIT-bit slice pair into the running (eq, gt) state.
//   Ports:
//     eq_in, gt_in    - cascade state from the more significant slices
//     slice_a/slice_b - current slice of each operand (unsigned)
//     eq_out, gt_out  - updated cascade state
module comp_slice #(
  parameter int DIGIT = 2
) (
  input  logic             eq_in,
  input  logic             gt_in,
  input  logic [DIGIT-1:0] slice_a,
  input  logic [DIGIT-1:0] slice_b,
  output logic             eq_out,
  output logic             gt_out
);

  // A lower slice can only decide the result while everything above it matched.
  assign gt_out = gt_in | (eq_in & (slice_a > slice_b));
  assign eq_out = eq_in & (slice_a == slice_b);

endmodule

// File: rtl/comp_seq.sv
`timescale 1ns/1ps
// comp_seq
//   Sequential magnitude comparator. Operands are latched on start and
//   compared DIGIT bits per cycle, most significant slice first, stopping as
//   soon as a slice differs. Signed comparison is done by flipping the sign
//   bit of both operands, which maps two's complement order onto unsigned order.
//   Ports:
//     clock, reset_n   - clock (rising edge) and asynchronous active-low reset
//     start            - latch a/b/signed_mode and begin (ignored while busy)
//     abort            - cancel a running comparison, no result produced
//     signed_mode      - 1: two's complement, 0: unsigned
//     a, b             - operands
//     busy             - high while comparing
//     done             - one-cycle pulse when eq/gt/lt have been updated
//     eq, gt, lt       - registered result, held until the next completion
module comp_seq
  import comp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int N     = (DIGIT >= 1) ? (WIDTH / DIGIT) : 1;
  localparam int IDX_W = idx_width(N);

  generate
    if (DIGIT < 1) begin : g_bad_digit
      $error("comp_seq: DIGIT must be at least 1");
    end else if ((WIDTH % DIGIT) != 0) begin : g_bad_width
      $error("comp_seq: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] idx;
  logic             cas_eq;
  logic             cas_gt;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic             mode_lat;
  logic [WIDTH-1:0] a_cmp;
  logic [WIDTH-1:0] b_cmp;
  logic [DIGIT-1:0] sl_a;
  logic [DIGIT-1:0] sl_b;
  logic             eq_nx;
  logic             gt_nx;
  logic             launch;
  logic             finish;

  assign launch = start && ((state == ST_IDLE) || (state == ST_DONE));
  // Abort wins over completion in the same cycle.
  assign finish = (state == ST_RUN) && !abort && (!eq_nx || (idx == '0));

  // Sign-bit flip only touches the top bit; every other slice compares as-is.
  always_comb begin
    a_cmp          = a_lat;
    b_cmp          = b_lat;
    a_cmp[WIDTH-1] = a_lat[WIDTH-1] ^ mode_lat;
    b_cmp[WIDTH-1] = b_lat[WIDTH-1] ^ mode_lat;
  end

  assign sl_a = a_cmp[int'(idx) * DIGIT +: DIGIT];
  assign sl_b = b_cmp[int'(idx) * DIGIT +: DIGIT];

  comp_slice #(
    .DIGIT (DIGIT)
  ) u_slice (
    .eq_in   (cas_eq),
    .gt_in   (cas_gt),
    .slice_a (sl_a),
    .slice_b (sl_b),
    .eq_out  (eq_nx),
    .gt_out  (gt_nx)
  );

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // FSM next state
  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE: state_nx = start ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        if (abort)       state_nx = ST_IDLE;
        else if (finish) state_nx = ST_DONE;
        else             state_nx = ST_RUN;
      end
      ST_DONE: state_nx = start ? ST_RUN : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  // Operand capture; data only, no reset needed.
  always_ff @(posedge clock) begin
    if (launch) begin
      a_lat    <= a;
      b_lat    <= b;
      mode_lat <= signed_mode;
    end
  end

  // Slice index, cascade state and result registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx    <= '0;
      cas_eq <= 1'b0;
      cas_gt <= 1'b0;
      eq     <= 1'b0;
      gt     <= 1'b0;
      lt     <= 1'b0;
    end else if (launch) begin
      idx    <= IDX_W'(N - 1);
      cas_eq <= 1'b1;
      cas_gt <= 1'b0;
    end else if ((state == ST_RUN) && !abort) begin
      idx    <= idx - 1'b1;
      cas_eq <= eq_nx;
      cas_gt <= gt_nx;
      if (finish) begin
        eq <= eq_nx;
        gt <= gt_nx;
        lt <= !eq_nx && !gt_nx;
      end
    end
  end

endmodule

// File: tb/tb_comp_seq.sv
`timescale 1ns/1ps
module tb_comp_seq;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int N     = WIDTH / DIGIT;

  logic             clock       = 1'b0;
  logic             reset_n     = 1'b0;
  logic             start       = 1'b0;
  logic             abort       = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH-1:0] a           = '0;
  logic [WIDTH-1:0] b           = '0;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;

  comp_seq #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .eq          (eq),
    .gt          (gt),
    .lt          (lt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int issue;
    int k;
    bit eq;
    bit gt;
    bit lt;
  } exp_t;

  exp_t sbq[$];
  int   total      = 0;
  int   bad        = 0;
  int   edge_count = 0;
  int   last_k     = 0;
  bit   h_eq       = 1'b0;
  bit   h_gt       = 1'b0;
  bit   h_lt       = 1'b0;

  always @(posedge clock) edge_count <= edge_count + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Reference: relation from plain integer compares; latency from the
  // position of the most significant differing bit.
  function automatic exp_t model(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                 input bit sm, input int issue);
    exp_t e;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0] diff;
    bit found;
    sa = va;
    sb = vb;
    e.issue = issue;
    e.eq = (va == vb);
    e.gt = sm ? (sa > sb) : (va > vb);
    e.lt = sm ? (sa < sb) : (va < vb);
    diff = va ^ vb;
    e.k = N;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && diff[i]) begin
        found = 1'b1;
        e.k = 1 + (WIDTH - 1 - i) / DIGIT;
      end
    end
    return e;
  endfunction

  // Monitor: pops an expectation on every done pulse and checks held outputs.
  always @(negedge clock) begin
    exp_t e;
    if (done) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", done, 0);
      end else begin
        e = sbq.pop_front();
        chk("latency", edge_count - e.issue, e.k);
        h_eq = e.eq;
        h_gt = e.gt;
        h_lt = e.lt;
      end
      chk("busy_in_done", busy, 0);
    end
    chk("eq_out", eq, h_eq);
    chk("gt_out", gt, h_gt);
    chk("lt_out", lt, h_lt);
  end

  // Drives start for exactly one edge; called at negedge+1.
  task automatic issue(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                       input bit sm, input bit push);
    exp_t e;
    start       = 1'b1;
    a           = va;
    b           = vb;
    signed_mode = sm;
    e = model(va, vb, sm, edge_count + 1);
    last_k = e.k;
    if (push) sbq.push_back(e);
    tick();
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
  endtask

  task automatic wait_done(input int exp_busy);
    int bc;
    bit seen;
    bc   = 0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (busy) bc++;
      if (done) seen = 1'b1;
      else      tick();
    end
    chk("done_seen", seen, 1);
    if (seen) chk("busy_cycles", bc, exp_busy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_eq", eq, 0);
    chk("rst_gt", gt, 0);
    chk("rst_lt", lt, 0);
    #2 reset_n = 1'b1;
    tick();
    tick();
    chk("idle_after_rst", busy, 0);

    // Equal operands run all slices
    issue(8'h5A, 8'h5A, 1'b0, 1'b1);
    wait_done(last_k);

    // MSB decides at once; sign flips the outcome
    issue(8'h80, 8'h7F, 1'b0, 1'b1);
    wait_done(last_k);
    issue(8'h80, 8'h7F, 1'b1, 1'b1);
    wait_done(last_k);

    // Difference only in the last slice
    tick();
    issue(8'h12, 8'h13, 1'b0, 1'b1);
    wait_done(last_k);

    // start during RUN is ignored, then back-to-back start from DONE
    issue(8'h40, 8'h41, 1'b0, 1'b1);
    tick();
    start = 1'b1;
    a     = 8'hFF;
    tick();
    start = 1'b0;
    wait_done(last_k - 2);
    issue(8'h03, 8'h01, 1'b0, 1'b1);
    wait_done(last_k);

    // Abort mid-RUN keeps the previous result
    issue(8'h5A, 8'h5A, 1'b0, 1'b1);
    wait_done(last_k);
    issue(8'h01, 8'h02, 1'b0, 1'b0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_eq", eq, 1);
    repeat (6) tick();

    // Abort beats completion in the same cycle
    issue(8'h80, 8'h00, 1'b0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_prio_busy", busy, 0);
    repeat (3) tick();

    // Abort outside RUN has no effect
    abort = 1'b1;
    issue(8'hC3, 8'hC7, 1'b0, 1'b1);
    abort = 1'b0;
    wait_done(last_k);

    // Asynchronous reset mid-RUN
    issue(8'h5A, 8'h5A, 1'b0, 1'b1);
    wait_done(last_k);
    issue(8'h01, 8'h02, 1'b0, 1'b0);
    tick();
    #2;
    reset_n = 1'b0;
    h_eq = 1'b0;
    h_gt = 1'b0;
    h_lt = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_eq", eq, 0);
    chk("arst_gt", gt, 0);
    chk("arst_lt", lt, 0);
    tick();
    #2 reset_n = 1'b1;
    repeat (6) tick();
    chk("post_rst_idle", busy, 0);

    // Randomized comparisons
    for (int it = 0; it < 80; it++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      bit rsm;
      ra  = WIDTH'($urandom);
      rsm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
        default: rb = WIDTH'($urandom);
      endcase
      issue(ra, rb, rsm, 1'b1);
      wait_done(last_k);
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    tick();
    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
